// File: rtl/alu_cc.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cc
//  Description : Add/subtract ALU with registered result and condition codes
//                (Zero, oVerflow, Carry/borrow, Negative). Supports ADD, ADC,
//                SUB and SBB with select priority SBB > SUB > ADC > ADD.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cc #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Pre_C,
    input  logic             ADC,
    input  logic             SUB,
    input  logic             SBB,
    output logic [WIDTH-1:0] Y,
    output logic             Z,
    output logic             V,
    output logic             C,
    output logic             N
);

    localparam int MSB = WIDTH - 1;

    // Decoded operation controls
    logic             op_sub;      // subtract family (SUB or SBB)
    logic             op_chain;    // uses Pre_C (ADC or SBB)
    logic             carry_in;    // adder carry input
    logic [WIDTH-1:0] b_operand;   // B or ~B depending on operation
    logic [WIDTH:0]   sum;         // full-width adder output incl. carry out
    logic [WIDTH-1:0] y_next;
    logic             z_next;
    logic             v_next;
    logic             c_next;
    logic             n_next;

    // Resolve the operation selects by priority; an undriven (X) select falls
    // through to the lower-priority branches, so the default is always ADD.
    always_comb begin
        op_sub   = 1'b0;
        op_chain = 1'b0;
        if (SBB == 1'b1) begin
            op_sub   = 1'b1;
            op_chain = 1'b1;
        end else if (SUB == 1'b1) begin
            op_sub   = 1'b1;
        end else if (ADC == 1'b1) begin
            op_chain = 1'b1;
        end
    end

    // Single shared adder: subtraction is A + ~B + cin. For SUB cin is 1
    // (two's complement); for SBB cin is ~Pre_C so that one extra unit is
    // taken away when a borrow is pending. For adds cin is Pre_C only on ADC.
    always_comb begin
        b_operand = op_sub ? ~B : B;
        if (op_sub) begin
            carry_in = op_chain ? ~Pre_C : 1'b1;
        end else begin
            carry_in = op_chain ? Pre_C : 1'b0;
        end
        sum = {1'b0, A} + {1'b0, b_operand} + {{WIDTH{1'b0}}, carry_in};
    end

    // Condition codes. A subtract borrow is the inverse of the adder carry,
    // which also gives the exact 17-bit "A < B + Pre_C" answer for SBB.
    always_comb begin
        y_next = sum[WIDTH-1:0];
        z_next = (y_next == {WIDTH{1'b0}});
        n_next = y_next[MSB];
        c_next = op_sub ? ~sum[WIDTH] : sum[WIDTH];
        if (op_sub) begin
            v_next = (A[MSB] != B[MSB]) && (y_next[MSB] != A[MSB]);
        end else begin
            v_next = (A[MSB] == B[MSB]) && (y_next[MSB] != A[MSB]);
        end
    end

    // Result and flags always load together every cycle; reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Y <= {WIDTH{1'b0}};
            Z <= 1'b0;
            V <= 1'b0;
            C <= 1'b0;
            N <= 1'b0;
        end else begin
            Y <= y_next;
            Z <= z_next;
            V <= v_next;
            C <= c_next;
            N <= n_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_cc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cc
//  Description : Scoreboard bench for alu_cc with directed vectors and
//                hand-computed expected results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cc;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic        Pre_C;
    logic        ADC;
    logic        SUB;
    logic        SBB;
    logic [15:0] Y;
    logic        Z;
    logic        V;
    logic        C;
    logic        N;

    typedef struct {
        string       name;
        logic [15:0] y;
        logic [3:0]  zvcn;
    } exp_t;

    exp_t q[$];
    int   vectors_applied = 0;
    int   miscompares     = 0;

    alu_cc #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .Pre_C (Pre_C),
        .ADC   (ADC),
        .SUB   (SUB),
        .SBB   (SBB),
        .Y     (Y),
        .Z     (Z),
        .V     (V),
        .C     (C),
        .N     (N)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: after every rising edge the DUT presents a new result; pop the
    // expectation issued for that edge and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors_applied++;
                if (Y !== e.y || {Z, V, C, N} !== e.zvcn) begin
                    miscompares++;
                    $display("FAIL %s: got Y=%h ZVCN=%b, expected Y=%h ZVCN=%b",
                             e.name, Y, {Z, V, C, N}, e.y, e.zvcn);
                end
            end
        end
    end

    // Drive one vector before the next rising edge and record its expectation.
    task automatic apply(input string nm, input logic adc_s, input logic sub_s,
                         input logic sbb_s, input logic [15:0] a, input logic [15:0] b,
                         input logic pc, input logic [15:0] ey, input logic [3:0] ezvcn);
        exp_t e;
        @(negedge clk);
        A = a; B = b; Pre_C = pc; ADC = adc_s; SUB = sub_s; SBB = sbb_s;
        e.name = nm; e.y = ey; e.zvcn = ezvcn;
        q.push_back(e);
    endtask

    task automatic check_reset(input string nm);
        vectors_applied++;
        if (Y !== 16'h0000 || {Z, V, C, N} !== 4'b0000) begin
            miscompares++;
            $display("FAIL %s: got Y=%h ZVCN=%b, expected Y=0000 ZVCN=0000",
                     nm, Y, {Z, V, C, N});
        end
    endtask

    task automatic drain(input string nm);
        int budget = 10;
        while (q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL %s: %0d expectations left unchecked, expected 0", nm, q.size());
            q.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        A = 16'h0; B = 16'h0; Pre_C = 1'b0; ADC = 1'b0; SUB = 1'b0; SBB = 1'b0;
        #1;
        check_reset("reset_initial");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        //      name             adc  sub  sbb  A        B        pc    Y        ZVCN
        apply("add_basic",       0,   0,   0,   16'h1234, 16'h2345, 0, 16'h3579, 4'b0000);
        apply("adc_pc0",         1,   0,   0,   16'h1234, 16'h2345, 0, 16'h3579, 4'b0000);
        apply("adc_pc1",         1,   0,   0,   16'h1234, 16'h2345, 1, 16'h357A, 4'b0000);
        apply("sub_borrow",      0,   1,   0,   16'h1234, 16'h2345, 0, 16'hEEEF, 4'b0011);
        apply("sub_ignores_pc",  0,   1,   0,   16'h1234, 16'h2345, 1, 16'hEEEF, 4'b0011);
        apply("sub_no_borrow",   0,   1,   0,   16'h2345, 16'h1234, 0, 16'h1111, 4'b0000);
        apply("sbb_pc0",         0,   0,   1,   16'h1234, 16'h2345, 0, 16'hEEEF, 4'b0011);
        apply("sbb_pc1",         0,   0,   1,   16'h1234, 16'h2345, 1, 16'hEEEE, 4'b0011);
        apply("add_pos_ovf",     0,   0,   0,   16'h7FFF, 16'h0001, 0, 16'h8000, 4'b0101);
        apply("add_wrap_zero",   0,   0,   0,   16'hFFFF, 16'h0001, 0, 16'h0000, 4'b1010);
        apply("adc_wrap_zero",   1,   0,   0,   16'hFFFF, 16'h0000, 1, 16'h0000, 4'b1010);
        apply("sub_neg_ovf",     0,   1,   0,   16'h8000, 16'h0001, 0, 16'h7FFF, 4'b0100);
        apply("sbb_zero_pc1",    0,   0,   1,   16'h0000, 16'h0000, 1, 16'hFFFF, 4'b0011);
        apply("prio_sbb_sub",    0,   1,   1,   16'h1234, 16'h2345, 1, 16'hEEEE, 4'b0011);
        apply("prio_sub_adc",    1,   1,   0,   16'h0005, 16'h0003, 1, 16'h0002, 4'b0000);
        apply("add_neg_ovf",     0,   0,   0,   16'h8000, 16'h8000, 0, 16'h0000, 4'b1110);
        apply("sbb_ffff_pc1",    0,   0,   1,   16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 4'b0011);
        apply("adc_max",         1,   0,   0,   16'hFFFF, 16'hFFFF, 1, 16'hFFFF, 4'b0011);
        drain("drain_main");

        // Mid-run asynchronous reset while outputs hold a nonzero value.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset("reset_async");
        @(posedge clk);
        #1;
        check_reset("reset_held");
        @(negedge clk);
        rst = 1'b0;

        apply("post_reset_add",  0,   0,   0,   16'h0001, 16'h0001, 0, 16'h0002, 4'b0000);
        drain("drain_post");

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_cc.md
Name: alu_cc

Overview:
16-bit add/subtract ALU with condition-code generation (Zero, oVerflow, Carry/borrow, Negative) for the single-cycle RISC datapath. Supported operations: ADD, ADC (add with carry-in), SUB and SBB (subtract with borrow-in). Operands and operation selects are sampled combinationally. Result and flags are registered, and the registered C output is normally fed back to the Pre_C input by the datapath.

Parameters:
WIDTH, 16, datapath width of A, B and Y (all behaviour below is stated for 16).

Ports:
clk  input  1  system clock; outputs update on the rising edge.
rst  input  1  asynchronous, active-high reset.
A  input  16  operand A (minuend for subtracts).
B  input  16  operand B (subtrahend for subtracts).
Pre_C  input  1  previous carry/borrow flag; used only by ADC and SBB.
ADC  input  1  select add-with-carry.
SUB  input  1  select subtract.
SBB  input  1  select subtract-with-borrow.
Y  output  16  registered result.
Z  output  1  registered zero flag.
V  output  1  registered signed-overflow flag.
C  output  1  registered carry (add) / borrow (subtract) flag.
N  output  1  registered negative flag.

Behaviour:
- Reset: while rst=1, Y=16'h0000 and Z=V=C=N=0, asynchronously. The first update after release happens on the first rising clk edge with rst=0.
- Latency: 1 cycle. Inputs present before rising edge k appear on Y/Z/V/C/N after edge k. There is no handshake, so the block computes every cycle.
- Operation select, priority SBB > SUB > ADC > ADD. ADD is the default when all selects are 0. Multiple asserted selects resolve by this priority.
- ADD: Y = A + B. C = carry out of bit 15.
- ADC: Y = A + B + Pre_C. C = carry out of bit 15.
- SUB: Y = A - B; Pre_C is ignored. C = 1 when a borrow occurs (unsigned A < B).
- SBB: Y = A - B - Pre_C. C = 1 when unsigned A < B + Pre_C, using a 17-bit compare.
- Width: all arithmetic is done in 17 bits. Y is bits [15:0] and wraps modulo 2^16.
- N = Y[15].
- Z = 1 when Y == 16'h0000.
- V on add (ADD/ADC) = (A[15]==B[15]) and (Y[15]!=A[15]).
- V on subtract (SUB/SBB) = (A[15]!=B[15]) and (Y[15]!=A[15]).
- Flag registers always load together with Y. There is no flag hold mode.
- Recommended structure: a single adder computing A + (B or ~B) + cin. The subtract borrow equals the inverted adder carry.
- The combinational next-state logic contains no latches. X on any select must not corrupt state after rst.

Test Plan:
- Reset: assert rst mid-run with nonzero outputs -> Y=0000, Z=V=C=N=0 immediately without a clock edge. Outputs stay there until rst falls.
- ADD/ADC: A=1234, B=2345, selects 0 -> Y=3579, ZVCN=0000. Then ADC=1 with Pre_C=0 -> Y=3579. Then Pre_C=1 -> Y=357A.
- SUB: A=1234, B=2345 -> Y=EEEF, N=1, C=1, V=0, Z=0. Same with Pre_C=1 -> Y=EEEF (Pre_C ignored). A=2345, B=1234 -> Y=1111, C=0, N=0.
- SBB: A=1234, B=2345, Pre_C=0 -> Y=EEEF, C=1. With Pre_C=1 -> Y=EEEE, C=1, N=1.
- Boundary add cases:
  - ADD 7FFF+0001 -> Y=8000, V=1, N=1, C=0.
  - ADD FFFF+0001 -> Y=0000, Z=1, C=1, V=0.
  - ADC FFFF+0000 with Pre_C=1 -> Y=0000, Z=1, C=1.
- Boundary subtract and priority cases:
  - SUB 8000-0001 -> Y=7FFF, V=1, C=0.
  - SBB 0000-0000 with Pre_C=1 -> Y=FFFF, C=1, N=1.
  - SUB=1 and SBB=1 together -> SBB result. Verify one-cycle latency on every case.
